pf_vf_rtable_lookup: RTL and testbench

Runtime-programmable PF/VF routing table for the host-side PF/VF mux, successor to the elaboration-time routing table. Each request carries a (PF, VF, vf_active) function ID and is resolved through a 2-stage pipeline into a mux port index, with priority matching, per-entry VF wildcards, a default port on miss, and a saturating miss counter. It sits between the PCIe SS TLP header decode and the PF/VF mux port select. Software can reprogram it through a config write port while traffic flows.

---
 rtl/pf_vf_rtable_lookup.sv | 190 +++++++++++++++++++
 tb/tb_pf_vf_rtable_lookup.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_vf_rtable_lookup.sv
// Runtime-programmable PF/VF routing table: resolves (pf, vf, vf_active) to a mux port
// through a two-stage pipeline with lowest-index priority, VF wildcards and a miss counter.
module pf_vf_rtable_lookup #(
    parameter int NUM_ENTRIES  = 16,
    parameter int PF_WIDTH     = 3,
    parameter int VF_WIDTH     = 11,
    parameter int NUM_PORT     = 8,
    parameter int PORT_WIDTH   = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1,
    parameter int DEFAULT_PORT = 0,
    parameter int TAG_WIDTH    = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int IDX_WIDTH    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PF_WIDTH-1:0]   req_pf,
    input  logic [VF_WIDTH-1:0]   req_vf,
    input  logic                  req_vf_active,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [PORT_WIDTH-1:0] rsp_port,
    output logic                  rsp_hit,
    output logic [IDX_WIDTH-1:0]  rsp_idx,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  cfg_wr_valid,
    input  logic [IDX_WIDTH-1:0]  cfg_wr_idx,
    input  logic                  cfg_wr_en_entry,
    input  logic [PF_WIDTH-1:0]   cfg_wr_pf,
    input  logic [VF_WIDTH-1:0]   cfg_wr_vf,
    input  logic                  cfg_wr_vf_active,
    input  logic                  cfg_wr_vf_wild,
    input  logic [PORT_WIDTH-1:0] cfg_wr_port,
    output logic                  cfg_err,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    typedef struct packed {
        logic                  valid;
        logic [PF_WIDTH-1:0]   pf;
        logic [VF_WIDTH-1:0]   vf;
        logic                  vf_active;
        logic                  vf_wild;
        logic [PORT_WIDTH-1:0] port;
    } entry_t;

    // Handshake: a request transfers on a clock edge where req_valid && req_ready;
    // a response transfers where rsp_valid && rsp_ready. Both stages move together on en.
    entry_t                  ent_q [NUM_ENTRIES];
    entry_t                  ent_d [NUM_ENTRIES];
    logic                    s1_valid_q, s1_valid_d;
    logic [NUM_ENTRIES-1:0]  s1_match_q, s1_match_d;
    logic [PORT_WIDTH-1:0]   s1_port_q, s1_port_d;
    logic [TAG_WIDTH-1:0]    s1_tag_q, s1_tag_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [PORT_WIDTH-1:0]   rsp_port_q, rsp_port_d;
    logic                    rsp_hit_q, rsp_hit_d;
    logic [IDX_WIDTH-1:0]    rsp_idx_q, rsp_idx_d;
    logic [TAG_WIDTH-1:0]    rsp_tag_q, rsp_tag_d;
    logic                    cfg_err_q, cfg_err_d;
    logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;

    logic                    en;
    logic [NUM_ENTRIES-1:0]  match;
    logic [PORT_WIDTH-1:0]   sel_port;
    logic                    enc_hit;
    logic [IDX_WIDTH-1:0]    enc_idx;
    logic                    wr_bad;

    assign en        = !rsp_valid_q || rsp_ready;
    assign req_ready = en;
    assign rsp_valid = rsp_valid_q;
    assign rsp_port  = rsp_port_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_tag   = rsp_tag_q;
    assign cfg_err   = cfg_err_q;
    assign miss_cnt  = miss_cnt_q;

    // The winning port is snapshotted in S1 so a later write to that entry cannot
    // change a result that is already in flight.
    always_comb begin
        match    = '0;
        sel_port = PORT_WIDTH'(DEFAULT_PORT);
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = ent_q[i].valid && (ent_q[i].pf == req_pf) &&
                       (ent_q[i].vf_active == req_vf_active) &&
                       (!ent_q[i].vf_active || ent_q[i].vf_wild || (ent_q[i].vf == req_vf));
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) sel_port = ent_q[i].port;
        end
    end

    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (s1_match_q[i]) begin
                enc_hit = 1'b1;
                enc_idx = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        wr_bad = cfg_wr_valid &&
                 ((32'(cfg_wr_idx) >= NUM_ENTRIES) ||
                  (cfg_wr_en_entry && (32'(cfg_wr_port) >= NUM_PORT)));
        cfg_err_d = wr_bad;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            if (cfg_wr_valid && !wr_bad && (32'(cfg_wr_idx) == i)) begin
                ent_d[i].valid     = cfg_wr_en_entry;
                ent_d[i].pf        = cfg_wr_pf;
                ent_d[i].vf        = cfg_wr_vf;
                ent_d[i].vf_active = cfg_wr_vf_active;
                ent_d[i].vf_wild   = cfg_wr_vf_wild;
                ent_d[i].port      = cfg_wr_port;
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_match_d  = s1_match_q;
        s1_port_d   = s1_port_q;
        s1_tag_d    = s1_tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_port_d  = rsp_port_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_tag_d   = rsp_tag_q;
        if (en) begin
            s1_valid_d = req_valid;
            if (req_valid) begin
                s1_match_d = match;
                s1_port_d  = sel_port;
                s1_tag_d   = req_tag;
            end
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_port_d = enc_hit ? s1_port_q : PORT_WIDTH'(DEFAULT_PORT);
                rsp_hit_d  = enc_hit;
                rsp_idx_d  = enc_idx;
                rsp_tag_d  = s1_tag_q;
            end
        end
        miss_cnt_d = miss_cnt_q;
        if (cnt_clr) begin
            miss_cnt_d = '0;
        end else if (rsp_valid_q && rsp_ready && !rsp_hit_q && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
            s1_valid_q  <= 1'b0;
            s1_match_q  <= '0;
            s1_port_q   <= '0;
            s1_tag_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_tag_q   <= '0;
            cfg_err_q   <= 1'b0;
            miss_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
            s1_valid_q  <= s1_valid_d;
            s1_match_q  <= s1_match_d;
            s1_port_q   <= s1_port_d;
            s1_tag_q    <= s1_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_tag_q   <= rsp_tag_d;
            cfg_err_q   <= cfg_err_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_pf_vf_rtable_lookup.sv
// Directed plus randomized bench for pf_vf_rtable_lookup against a first-match table model.
module tb_pf_vf_rtable_lookup;

    localparam int NE   = 12;
    localparam int NP   = 7;
    localparam int DP   = 2;
    localparam int PFW  = 3;
    localparam int VFW  = 11;
    localparam int TW   = 8;
    localparam int CW   = 4;
    localparam int PW   = 3;
    localparam int IW   = 4;
    localparam int EW   = TW + IW + 1 + PW;
    localparam int CMAX = 15;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid, req_ready, req_vf_active;
    logic [PFW-1:0] req_pf;
    logic [VFW-1:0] req_vf;
    logic [TW-1:0]  req_tag;
    logic           rsp_valid, rsp_ready, rsp_hit;
    logic [PW-1:0]  rsp_port;
    logic [IW-1:0]  rsp_idx;
    logic [TW-1:0]  rsp_tag;
    logic           cfg_wr_valid, cfg_wr_en_entry, cfg_wr_vf_active, cfg_wr_vf_wild;
    logic [IW-1:0]  cfg_wr_idx;
    logic [PFW-1:0] cfg_wr_pf;
    logic [VFW-1:0] cfg_wr_vf;
    logic [PW-1:0]  cfg_wr_port;
    logic           cfg_err, cnt_clr;
    logic [CW-1:0]  miss_cnt;

    always #5 clk = ~clk;

    pf_vf_rtable_lookup #(
        .NUM_ENTRIES(NE), .PF_WIDTH(PFW), .VF_WIDTH(VFW), .NUM_PORT(NP),
        .DEFAULT_PORT(DP), .TAG_WIDTH(TW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_pf(req_pf), .req_vf(req_vf),
        .req_vf_active(req_vf_active), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx), .rsp_tag(rsp_tag),
        .cfg_wr_valid(cfg_wr_valid), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_en_entry(cfg_wr_en_entry),
        .cfg_wr_pf(cfg_wr_pf), .cfg_wr_vf(cfg_wr_vf), .cfg_wr_vf_active(cfg_wr_vf_active),
        .cfg_wr_vf_wild(cfg_wr_vf_wild), .cfg_wr_port(cfg_wr_port), .cfg_err(cfg_err),
        .cnt_clr(cnt_clr), .miss_cnt(miss_cnt)
    );

    // Reference table and scoreboard
    logic           m_valid [NE];
    logic [PFW-1:0] m_pf    [NE];
    logic [VFW-1:0] m_vf    [NE];
    logic           m_vfa   [NE];
    logic           m_wild  [NE];
    logic [PW-1:0]  m_port  [NE];
    logic [EW-1:0]  exp_q[$];
    int             m_cnt;
    logic           exp_err;
    int             n_checks = 0;
    int             n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0; m_pf[i] = '0; m_vf[i] = '0;
            m_vfa[i] = 1'b0; m_wild[i] = 1'b0; m_port[i] = '0;
        end
        exp_q.delete();
        m_cnt = 0;
        exp_err = 1'b0;
    endtask

    // First entry in index order satisfying the match rule wins; otherwise default port.
    function automatic logic [EW-1:0] model_lookup(input logic [PFW-1:0] pf, input logic [VFW-1:0] vf,
                                                   input logic vfa, input logic [TW-1:0] tag);
        for (int i = 0; i < NE; i++) begin
            if (m_valid[i] && m_pf[i] == pf && m_vfa[i] == vfa && (!vfa || m_wild[i] || m_vf[i] == vf))
                return {tag, IW'(i), 1'b1, m_port[i]};
        end
        return {tag, IW'(0), 1'b0, PW'(DP)};
    endfunction

    task automatic set_req(input int pf, input int vf, input logic vfa, input int tag);
        req_pf = PFW'(pf); req_vf = VFW'(vf); req_vf_active = vfa; req_tag = TW'(tag);
        req_valid = 1'b1;
    endtask

    task automatic cfg_write(input int idx, input logic en, input int pf, input int vf,
                             input logic vfa, input logic wild, input int port);
        cfg_wr_idx = IW'(idx); cfg_wr_en_entry = en; cfg_wr_pf = PFW'(pf); cfg_wr_vf = VFW'(vf);
        cfg_wr_vf_active = vfa; cfg_wr_vf_wild = wild; cfg_wr_port = PW'(port);
        cfg_wr_valid = 1'b1;
    endtask

    // One clock: predict from the pre-edge view, advance, then check post-edge state.
    task automatic tick();
        logic          acc, hs, stall, inc;
        logic [EW-1:0] e, held;
        #1;
        acc   = req_valid && req_ready;
        hs    = rsp_valid && rsp_ready;
        stall = rsp_valid && !rsp_ready;
        held  = {rsp_tag, rsp_idx, rsp_hit, rsp_port};
        if (stall) chk("req_ready_stall", req_ready, 0);
        else       chk("req_ready_open", req_ready, 1);
        inc = 1'b0;
        if (hs) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp", held, e);
                inc = !e[PW];
            end
        end
        if (cnt_clr) m_cnt = 0;
        else if (inc) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        if (acc) exp_q.push_back(model_lookup(req_pf, req_vf, req_vf_active, req_tag));
        exp_err = 1'b0;
        if (cfg_wr_valid) begin
            if (32'(cfg_wr_idx) >= NE || (cfg_wr_en_entry && 32'(cfg_wr_port) >= NP)) exp_err = 1'b1;
            else begin
                m_valid[cfg_wr_idx] = cfg_wr_en_entry; m_pf[cfg_wr_idx] = cfg_wr_pf;
                m_vf[cfg_wr_idx] = cfg_wr_vf; m_vfa[cfg_wr_idx] = cfg_wr_vf_active;
                m_wild[cfg_wr_idx] = cfg_wr_vf_wild; m_port[cfg_wr_idx] = cfg_wr_port;
            end
        end
        @(posedge clk);
        #1;
        chk("cfg_err", cfg_err, exp_err);
        chk("miss_cnt", miss_cnt, m_cnt);
        if (stall) chk("stall_hold", {rsp_valid, rsp_tag, rsp_idx, rsp_hit, rsp_port}, {1'b1, held});
        if (acc) req_valid = 1'b0;
        cfg_wr_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || rsp_valid); i++) tick();
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sent;
        req_valid = 0; req_pf = '0; req_vf = '0; req_vf_active = 0; req_tag = '0;
        rsp_ready = 1; cfg_wr_valid = 0; cfg_wr_idx = '0; cfg_wr_en_entry = 0; cfg_wr_pf = '0;
        cfg_wr_vf = '0; cfg_wr_vf_active = 0; cfg_wr_vf_wild = 0; cfg_wr_port = '0; cnt_clr = 0;
        model_clear();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_port", rsp_port, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_idx", rsp_idx, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 0;

        // Miss on an empty table, with latency check
        set_req(1, 0, 0, 'h11);
        tick();
        chk("lat_not_yet", rsp_valid, 0);
        tick();
        chk("lat_valid", rsp_valid, 1);
        chk("miss_port", rsp_port, DP);
        chk("miss_hit", rsp_hit, 0);
        chk("miss_idx", rsp_idx, 0);
        tick();
        chk("miss_cnt_1", miss_cnt, 1);

        // Exact VF entry beats a higher-index wildcard
        cfg_write(3, 1, 2, 0, 1, 1, 5);
        tick();
        cfg_write(1, 1, 2, 7, 1, 0, 4);
        tick();
        set_req(2, 7, 1, 'h21);
        tick();
        set_req(2, 9, 1, 'h22);
        tick();
        chk("exact_port", rsp_port, 4);
        chk("exact_idx", rsp_idx, 1);
        tick();
        chk("wild_port", rsp_port, 5);
        chk("wild_idx", rsp_idx, 3);
        tick();

        // Write in the same cycle as a matching request: old contents apply
        cfg_write(0, 1, 4, 0, 0, 0, 6);
        set_req(4, 0, 0, 'h31);
        tick();
        set_req(4, 0, 0, 'h32);
        tick();
        chk("same_cycle_hit", rsp_hit, 0);
        tick();
        chk("after_write_port", rsp_port, 6);
        chk("after_write_hit", rsp_hit, 1);
        tick();
        drain();

        // Back-to-back stream with rsp_ready pattern 1,0,0,1
        sent = 0;
        for (int c = 0; c < 60 && (sent < 8 || exp_q.size() > 0); c++) begin
            if (sent < 8 && !req_valid) set_req(sent % 3 == 0 ? 2 : 4, sent, sent % 3 == 0, 'h80 + sent);
            rsp_ready = (c % 4 == 0) || (c % 4 == 3);
            tick();
            if (!req_valid && sent < 8 && req_tag == TW'('h80 + sent)) sent++;
        end
        chk("stream_sent", sent, 8);
        drain();

        // Rejected writes leave the table alone; disabled entries skip the port check
        cfg_write(5, 1, 5, 0, 0, 0, 7);
        tick();
        chk("bad_port_err", cfg_err, 1);
        tick();
        chk("err_one_cycle", cfg_err, 0);
        cfg_write(12, 1, 5, 0, 0, 0, 1);
        tick();
        chk("bad_idx_err", cfg_err, 1);
        cfg_write(4, 0, 5, 0, 0, 0, 7);
        tick();
        chk("disable_no_err", cfg_err, 0);
        set_req(5, 0, 0, 'h51);
        tick();
        tick();
        chk("unchanged_miss", rsp_hit, 0);
        tick();

        // Randomized traffic, writes and clears
        for (int c = 0; c < 300; c++) begin
            if (!req_valid && $urandom_range(0, 3) != 0)
                set_req($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
            rsp_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0)
                cfg_write($urandom_range(0, 13), ($urandom_range(0, 4) != 0), $urandom_range(0, 3),
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) cnt_clr = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        drain();

        // Saturation of the miss counter and clear priority
        for (int i = 0; i < NE; i++) begin
            cfg_write(i, 0, 0, 0, 0, 0, 0);
            tick();
        end
        cnt_clr = 1'b1;
        tick();
        sent = 0;
        for (int c = 0; c < 40 && sent < 16; c++) begin
            if (!req_valid) set_req(c % 8, c, c % 2, c);
            tick();
            if (!req_valid) sent++;
        end
        drain();
        chk("miss_saturated", miss_cnt, 15);
        set_req(1, 0, 0, 'hA0);
        tick();
        tick();
        cnt_clr = 1'b1;
        tick();
        chk("clr_beats_inc", miss_cnt, 0);

        // Reset with requests in flight: dropped, table forgotten
        cfg_write(1, 1, 2, 7, 1, 0, 4);
        tick();
        set_req(2, 7, 1, 'h91);
        tick();
        set_req(2, 7, 1, 'h92);
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_tag", rsp_tag, 0);
        rst = 1'b0;
        set_req(2, 7, 1, 'h93);
        tick();
        tick();
        chk("post_rst_miss", rsp_hit, 0);
        chk("post_rst_tag", rsp_tag, 'h93);
        tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
